umi_req_limiter: RTL and testbench
==================================

Name: umi_req_limiter

Overview:
- Inline UMI host-port stage between an AXI-to-UMI bridge's uhost_req/uhost_resp port and a UMI device such as the memory agent.
- Caps the number of in-flight non-posted requests by back-pressuring the request channel.
- Tracks outstanding responses and runs a response watchdog.
- Reports sticky underflow/timeout errors and an idle flag for drain/quiesce logic.

Parameters:
- DW, 64, UMI data width
- AW, 64, UMI address width
- CW, 32, UMI command width
- MAXOUT, 8, maximum outstanding non-posted requests (1..2^CNTW-1)
- CNTW, 4, outstanding counter width
- TIMEOUT, 4096, cycles without a response before timeout_err (0 = watchdog disabled)
- TOW, 16, watchdog counter width

Ports:
- clk  input  1  clock
- nreset  input  1  asynchronous active-low reset
- uhost_req_valid/cmd/dstaddr/srcaddr/data  input  1/CW/AW/AW/DW  upstream request
- uhost_req_ready  output  1  upstream request ready
- uhost_resp_valid/cmd/dstaddr/srcaddr/data  output  1/CW/AW/AW/DW  upstream response
- uhost_resp_ready  input  1  upstream response ready
- udev_req_valid/cmd/dstaddr/srcaddr/data  output  1/CW/AW/AW/DW  downstream request
- udev_req_ready  input  1  downstream request ready
- udev_resp_valid/cmd/dstaddr/srcaddr/data  input  1/CW/AW/AW/DW  downstream response
- udev_resp_ready  output  1  downstream response ready
- err_clear  input  1  clears sticky error flags
- outstanding  output  CNTW  current in-flight non-posted count
- idle  output  1  outstanding==0
- timeout_err  output  1  sticky watchdog error
- underflow_err  output  1  sticky unexpected-response error

Behaviour:
- Clock/reset: single clock clk; nreset asynchronous, active-low.
- Reset values: outstanding=0, idle=1, timeout_err=0, underflow_err=0, watchdog=0. Handshake outputs are combinational.
- cmd decode: opcode=cmd[4:0], eom=cmd[22].
- Non-posted requests: REQ_RD 0x01, REQ_WR 0x03, REQ_ATOMIC 0x09.
- Counted responses: RESP_READ 0x02, RESP_WR 0x04.
- All other opcodes pass through uncounted.
- Request path: zero latency, no storage.
  - udev_req_* = uhost_req_* except valid.
  - block = (opcode is non-posted) & (outstanding >= MAXOUT).
  - udev_req_valid = uhost_req_valid & ~block.
  - uhost_req_ready = udev_req_ready & ~block.
  - A blocked beat keeps uhost_req_ready=0; valid is never dropped by the source.
  - Posted traffic is never blocked.
- Response path: pure passthrough. udev_resp_* to uhost_resp_*, udev_resp_ready = uhost_resp_ready.
- inc: request handshake with a non-posted opcode and eom=1 (counted once per message, at the last beat).
- dec: response handshake with a counted opcode and eom=1.
- Counter update:
  - inc only: +1.
  - dec only: -1 if outstanding>0.
  - inc & dec: unchanged.
  - dec with outstanding==0: count stays 0, underflow_err set. If inc coincides, count becomes 1 and underflow_err is not set.
  - Count never exceeds MAXOUT: gating makes inc impossible at MAXOUT. Mid-message beats are safe because the count cannot rise before eom.
- Watchdog (TIMEOUT>0):
  - Cleared when outstanding==0 or on any dec.
  - Otherwise increments each cycle, saturating.
  - When the counter reaches TIMEOUT-1 with no dec that cycle, timeout_err sets on the next edge.
  - The watchdog holds at saturation; no re-arm until a dec occurs.
- Sticky flags: err_clear clears both flags; a set condition in the same cycle wins over err_clear.
- No effect on traffic after errors; flags are status only.
- Reset mid-operation: counter and flags return to reset values. In-flight responses arriving after reset are counted as underflow.

Test Plan:
- MAXOUT=2, hold udev_resp quiet, issue 3 single-beat REQ_RD → first two pass; third held with uhost_req_ready=0; outstanding=2, idle=0. One RESP_READ eom → third request forwarded the same cycle gating drops; outstanding returns to 2.
- With outstanding=MAXOUT, issue REQ_WRPOSTED 0x05 → forwarded immediately; outstanding unchanged.
- 3-beat REQ_WR (eom only on beat 3) at outstanding=0 → outstanding 0,0,1 after each beat. RESP_WR eom → 0, idle=1.
- Request eom handshake and response eom handshake in the same cycle at outstanding=1 → stays 1, no errors.
- RESP_READ eom at outstanding=0 → underflow_err=1, outstanding=0. err_clear pulse → flag cleared next edge.
- TIMEOUT=16, one REQ_RD, no response → timeout_err rises 16 cycles after the request handshake. Response then arrives → outstanding=0, timeout_err stays 1 until err_clear.

Source files
------------

// File: rtl/umi_req_limiter.sv
// Inline UMI host-port stage: limits in-flight non-posted requests, tracks
// outstanding responses, and runs a response watchdog with sticky status flags.
module umi_req_limiter #(
  parameter int DW      = 64,
  parameter int AW      = 64,
  parameter int CW      = 32,
  parameter int MAXOUT  = 8,
  parameter int CNTW    = 4,
  parameter int TIMEOUT = 4096,
  parameter int TOW     = 16
) (
  input  logic            clk,
  input  logic            nreset,
  // upstream request
  input  logic            uhost_req_valid,
  input  logic [CW-1:0]   uhost_req_cmd,
  input  logic [AW-1:0]   uhost_req_dstaddr,
  input  logic [AW-1:0]   uhost_req_srcaddr,
  input  logic [DW-1:0]   uhost_req_data,
  output logic            uhost_req_ready,
  // upstream response
  output logic            uhost_resp_valid,
  output logic [CW-1:0]   uhost_resp_cmd,
  output logic [AW-1:0]   uhost_resp_dstaddr,
  output logic [AW-1:0]   uhost_resp_srcaddr,
  output logic [DW-1:0]   uhost_resp_data,
  input  logic            uhost_resp_ready,
  // downstream request
  output logic            udev_req_valid,
  output logic [CW-1:0]   udev_req_cmd,
  output logic [AW-1:0]   udev_req_dstaddr,
  output logic [AW-1:0]   udev_req_srcaddr,
  output logic [DW-1:0]   udev_req_data,
  input  logic            udev_req_ready,
  // downstream response
  input  logic            udev_resp_valid,
  input  logic [CW-1:0]   udev_resp_cmd,
  input  logic [AW-1:0]   udev_resp_dstaddr,
  input  logic [AW-1:0]   udev_resp_srcaddr,
  input  logic [DW-1:0]   udev_resp_data,
  output logic            udev_resp_ready,
  // status
  input  logic            err_clear,
  output logic [CNTW-1:0] outstanding,
  output logic            idle,
  output logic            timeout_err,
  output logic            underflow_err
);

  localparam logic [4:0] REQ_RD     = 5'h01;
  localparam logic [4:0] REQ_WR     = 5'h03;
  localparam logic [4:0] REQ_ATOMIC = 5'h09;
  localparam logic [4:0] RESP_READ  = 5'h02;
  localparam logic [4:0] RESP_WR    = 5'h04;

  localparam logic [CNTW-1:0] MAXOUT_C = CNTW'(MAXOUT);
  localparam logic [TOW-1:0]  TO_LAST  = TOW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [TOW-1:0]  TO_SAT   = TOW'(TIMEOUT);

  function automatic logic is_nonposted(input logic [4:0] op);
    return (op == REQ_RD) || (op == REQ_WR) || (op == REQ_ATOMIC);
  endfunction

  function automatic logic is_counted(input logic [4:0] op);
    return (op == RESP_READ) || (op == RESP_WR);
  endfunction

  logic [CNTW-1:0] outstanding_q, outstanding_d;
  logic            idle_q, idle_d;
  logic            timeout_q, timeout_d;
  logic            underflow_q, underflow_d;
  logic [TOW-1:0]  wd_q, wd_d;

  logic block_s, inc_s, dec_s, uf_set_s, to_set_s;
  logic req_np_s, req_eom_s, resp_cnt_s, resp_eom_s;

  assign req_np_s   = is_nonposted(uhost_req_cmd[4:0]);
  assign req_eom_s  = uhost_req_cmd[22];
  assign resp_cnt_s = is_counted(udev_resp_cmd[4:0]);
  assign resp_eom_s = udev_resp_cmd[22];

  // Gating only stalls non-posted beats; the count cannot rise mid-message,
  // so a multi-beat message that started below the cap is never split.
  assign block_s = req_np_s & (outstanding_q >= MAXOUT_C);

  assign udev_req_valid   = uhost_req_valid & ~block_s;
  assign uhost_req_ready  = udev_req_ready & ~block_s;
  assign udev_req_cmd     = uhost_req_cmd;
  assign udev_req_dstaddr = uhost_req_dstaddr;
  assign udev_req_srcaddr = uhost_req_srcaddr;
  assign udev_req_data    = uhost_req_data;

  assign uhost_resp_valid   = udev_resp_valid;
  assign uhost_resp_cmd     = udev_resp_cmd;
  assign uhost_resp_dstaddr = udev_resp_dstaddr;
  assign uhost_resp_srcaddr = udev_resp_srcaddr;
  assign uhost_resp_data    = udev_resp_data;
  assign udev_resp_ready    = uhost_resp_ready;

  assign inc_s = uhost_req_valid & uhost_req_ready & req_np_s & req_eom_s;
  assign dec_s = udev_resp_valid & uhost_resp_ready & resp_cnt_s & resp_eom_s;

  // Outstanding counter next state; a response at zero count is ignored.
  always_comb begin
    outstanding_d = outstanding_q;
    uf_set_s      = 1'b0;
    if (inc_s && dec_s) begin
      if (outstanding_q == {CNTW{1'b0}}) begin
        outstanding_d = CNTW'(1);
      end else begin
        outstanding_d = outstanding_q;
      end
    end else if (inc_s) begin
      outstanding_d = outstanding_q + CNTW'(1);
    end else if (dec_s) begin
      if (outstanding_q != {CNTW{1'b0}}) begin
        outstanding_d = outstanding_q - CNTW'(1);
      end else begin
        uf_set_s = 1'b1;
      end
    end else begin
      outstanding_d = outstanding_q;
    end
    idle_d = (outstanding_d == {CNTW{1'b0}});
  end

  // Watchdog saturates one past the firing point so it fires once per stall.
  always_comb begin
    wd_d     = wd_q;
    to_set_s = 1'b0;
    if (TIMEOUT == 0) begin
      wd_d = {TOW{1'b0}};
    end else if ((outstanding_q == {CNTW{1'b0}}) || dec_s) begin
      wd_d = {TOW{1'b0}};
    end else begin
      to_set_s = (wd_q == TO_LAST);
      if (wd_q == TO_SAT) begin
        wd_d = wd_q;
      end else begin
        wd_d = wd_q + TOW'(1);
      end
    end
  end

  // Sticky error flags: a new set event wins over err_clear.
  always_comb begin
    if (uf_set_s) begin
      underflow_d = 1'b1;
    end else if (err_clear) begin
      underflow_d = 1'b0;
    end else begin
      underflow_d = underflow_q;
    end
    if (to_set_s) begin
      timeout_d = 1'b1;
    end else if (err_clear) begin
      timeout_d = 1'b0;
    end else begin
      timeout_d = timeout_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      outstanding_q <= {CNTW{1'b0}};
      idle_q        <= 1'b1;
      timeout_q     <= 1'b0;
      underflow_q   <= 1'b0;
      wd_q          <= {TOW{1'b0}};
    end else begin
      outstanding_q <= outstanding_d;
      idle_q        <= idle_d;
      timeout_q     <= timeout_d;
      underflow_q   <= underflow_d;
      wd_q          <= wd_d;
    end
  end

  assign outstanding   = outstanding_q;
  assign idle          = idle_q;
  assign timeout_err   = timeout_q;
  assign underflow_err = underflow_q;

endmodule

// File: tb/tb_umi_req_limiter.sv
// Scoreboard bench for umi_req_limiter: directed scenarios followed by random
// traffic, checked against a transaction-level model of the limiter.
module tb_umi_req_limiter;

  localparam int MAXOUT  = 2;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        nreset;
  logic        uhost_req_valid, uhost_req_ready;
  logic [31:0] uhost_req_cmd;
  logic [63:0] uhost_req_dstaddr, uhost_req_srcaddr, uhost_req_data;
  logic        uhost_resp_valid, uhost_resp_ready;
  logic [31:0] uhost_resp_cmd;
  logic [63:0] uhost_resp_dstaddr, uhost_resp_srcaddr, uhost_resp_data;
  logic        udev_req_valid, udev_req_ready;
  logic [31:0] udev_req_cmd;
  logic [63:0] udev_req_dstaddr, udev_req_srcaddr, udev_req_data;
  logic        udev_resp_valid, udev_resp_ready;
  logic [31:0] udev_resp_cmd;
  logic [63:0] udev_resp_dstaddr, udev_resp_srcaddr, udev_resp_data;
  logic        err_clear;
  logic [3:0]  outstanding;
  logic        idle, timeout_err, underflow_err;

  umi_req_limiter #(.DW(64), .AW(64), .CW(32), .MAXOUT(MAXOUT), .CNTW(4),
                    .TIMEOUT(TIMEOUT), .TOW(16)) dut (
    .clk(clk), .nreset(nreset),
    .uhost_req_valid(uhost_req_valid), .uhost_req_cmd(uhost_req_cmd),
    .uhost_req_dstaddr(uhost_req_dstaddr), .uhost_req_srcaddr(uhost_req_srcaddr),
    .uhost_req_data(uhost_req_data), .uhost_req_ready(uhost_req_ready),
    .uhost_resp_valid(uhost_resp_valid), .uhost_resp_cmd(uhost_resp_cmd),
    .uhost_resp_dstaddr(uhost_resp_dstaddr), .uhost_resp_srcaddr(uhost_resp_srcaddr),
    .uhost_resp_data(uhost_resp_data), .uhost_resp_ready(uhost_resp_ready),
    .udev_req_valid(udev_req_valid), .udev_req_cmd(udev_req_cmd),
    .udev_req_dstaddr(udev_req_dstaddr), .udev_req_srcaddr(udev_req_srcaddr),
    .udev_req_data(udev_req_data), .udev_req_ready(udev_req_ready),
    .udev_resp_valid(udev_resp_valid), .udev_resp_cmd(udev_resp_cmd),
    .udev_resp_dstaddr(udev_resp_dstaddr), .udev_resp_srcaddr(udev_resp_srcaddr),
    .udev_resp_data(udev_resp_data), .udev_resp_ready(udev_resp_ready),
    .err_clear(err_clear), .outstanding(outstanding), .idle(idle),
    .timeout_err(timeout_err), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         dv, hr, rr, hv;
    logic [223:0] req_pl, resp_pl;
    logic [3:0]   cnt;
    logic         idl, terr, uerr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state: plain message counts and stall length.
  int m_cnt, m_quiet;
  bit m_terr, m_uerr;

  function automatic bit is_np(input logic [4:0] op);
    return (op == 5'h01) || (op == 5'h03) || (op == 5'h09);
  endfunction

  function automatic bit is_resp(input logic [4:0] op);
    return (op == 5'h02) || (op == 5'h04);
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_quiet = 0; m_terr = 1'b0; m_uerr = 1'b0;
  endtask

  // One clock cycle: drive inputs, queue the expected response, advance the model.
  task automatic cyc(input bit rv, input logic [4:0] rop, input bit reom, input bit drdy,
                     input bit sv, input logic [4:0] sop, input bit seom, input bit hrdy,
                     input bit clr);
    logic [31:0] c;
    exp_t e;
    bit blk, inc, dec, uf, fire;
    c = $urandom; c[4:0] = rop; c[22] = reom;
    uhost_req_valid = rv; uhost_req_cmd = c;
    uhost_req_dstaddr = {$urandom, $urandom};
    uhost_req_srcaddr = {$urandom, $urandom};
    uhost_req_data = {$urandom, $urandom};
    c = $urandom; c[4:0] = sop; c[22] = seom;
    udev_resp_valid = sv; udev_resp_cmd = c;
    udev_resp_dstaddr = {$urandom, $urandom};
    udev_resp_srcaddr = {$urandom, $urandom};
    udev_resp_data = {$urandom, $urandom};
    udev_req_ready = drdy; uhost_resp_ready = hrdy; err_clear = clr;
    blk = is_np(rop) && (m_cnt >= MAXOUT);
    e.dv = rv && !blk;
    e.hr = drdy && !blk;
    e.rr = hrdy;
    e.hv = sv;
    e.req_pl  = {uhost_req_cmd, uhost_req_dstaddr, uhost_req_srcaddr, uhost_req_data};
    e.resp_pl = {udev_resp_cmd, udev_resp_dstaddr, udev_resp_srcaddr, udev_resp_data};
    e.cnt = 4'(m_cnt);
    e.idl = (m_cnt == 0);
    e.terr = m_terr;
    e.uerr = m_uerr;
    sb.push_back(e);
    @(posedge clk);
    inc = rv && e.hr && is_np(rop) && reom;
    dec = sv && hrdy && is_resp(sop) && seom;
    uf = dec && !inc && (m_cnt == 0);
    if (m_cnt == 0 || dec) m_quiet = 0;
    else m_quiet++;
    fire = (TIMEOUT > 0) && (m_quiet == TIMEOUT);
    m_cnt = m_cnt + (inc ? 1 : 0) - ((dec && m_cnt > 0) ? 1 : 0);
    m_uerr = uf ? 1'b1 : (clr ? 1'b0 : m_uerr);
    m_terr = fire ? 1'b1 : (clr ? 1'b0 : m_terr);
    #1;
  endtask

  task automatic req(input logic [4:0] op, input bit eom);
    cyc(1'b1, op, eom, 1'b1, 1'b0, 5'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic rsp(input logic [4:0] op, input bit eom);
    cyc(1'b0, 5'h00, 1'b0, 1'b1, 1'b1, op, eom, 1'b1, 1'b0);
  endtask

  task automatic quiet(input bit clr);
    cyc(1'b0, 5'h00, 1'b0, 1'b1, 1'b0, 5'h00, 1'b0, 1'b1, clr);
  endtask

  task automatic chk_status(input string nm, input logic [3:0] cnt, input bit idl,
                            input bit terr, input bit uerr);
    chk({nm, "_outstanding"}, outstanding, cnt);
    chk({nm, "_idle"}, idle, idl);
    chk({nm, "_timeout_err"}, timeout_err, terr);
    chk({nm, "_underflow_err"}, underflow_err, uerr);
  endtask

  // Monitor: compare whatever the DUT presents against the queued expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("udev_req_valid", udev_req_valid, mon_e.dv);
      chk("uhost_req_ready", uhost_req_ready, mon_e.hr);
      chk("udev_resp_ready", udev_resp_ready, mon_e.rr);
      chk("uhost_resp_valid", uhost_resp_valid, mon_e.hv);
      chk("req_payload", {udev_req_cmd, udev_req_dstaddr, udev_req_srcaddr, udev_req_data},
          mon_e.req_pl);
      chk("resp_payload", {uhost_resp_cmd, uhost_resp_dstaddr, uhost_resp_srcaddr,
          uhost_resp_data}, mon_e.resp_pl);
      chk("outstanding", outstanding, mon_e.cnt);
      chk("idle", idle, mon_e.idl);
      chk("timeout_err", timeout_err, mon_e.terr);
      chk("underflow_err", underflow_err, mon_e.uerr);
    end
  end

  initial begin
    logic [4:0] ops [8];
    ops = '{5'h01, 5'h03, 5'h09, 5'h02, 5'h04, 5'h05, 5'h00, 5'h07};
    nreset = 1'b0;
    uhost_req_valid = 1'b0; uhost_req_cmd = 32'h0;
    uhost_req_dstaddr = 64'h0; uhost_req_srcaddr = 64'h0; uhost_req_data = 64'h0;
    udev_resp_valid = 1'b0; udev_resp_cmd = 32'h0;
    udev_resp_dstaddr = 64'h0; udev_resp_srcaddr = 64'h0; udev_resp_data = 64'h0;
    udev_req_ready = 1'b0; uhost_resp_ready = 1'b0; err_clear = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_status("reset", 4'd0, 1'b1, 1'b0, 1'b0);
    nreset = 1'b1;

    // Cap at two: third read stalls until a response retires one.
    req(5'h01, 1'b1);
    req(5'h01, 1'b1);
    chk_status("cap_full", 4'd2, 1'b0, 1'b0, 1'b0);
    req(5'h01, 1'b1);
    req(5'h01, 1'b1);
    chk("cap_held_ready", uhost_req_ready, 1'b0);
    cyc(1'b1, 5'h01, 1'b1, 1'b1, 1'b1, 5'h02, 1'b1, 1'b1, 1'b0);
    chk("cap_after_resp", outstanding, 4'd1);
    req(5'h01, 1'b1);
    chk("cap_refill", outstanding, 4'd2);
    req(5'h05, 1'b1);
    chk("posted_at_cap", outstanding, 4'd2);
    rsp(5'h02, 1'b1);
    rsp(5'h02, 1'b1);
    chk_status("drained", 4'd0, 1'b1, 1'b0, 1'b0);

    // Multi-beat write counts once, at the last beat.
    req(5'h03, 1'b0);
    chk("mb_beat1", outstanding, 4'd0);
    req(5'h03, 1'b0);
    chk("mb_beat2", outstanding, 4'd0);
    req(5'h03, 1'b1);
    chk("mb_beat3", outstanding, 4'd1);
    rsp(5'h04, 1'b1);
    chk_status("mb_resp", 4'd0, 1'b1, 1'b0, 1'b0);

    // Simultaneous inc and dec at one.
    req(5'h01, 1'b1);
    cyc(1'b1, 5'h01, 1'b1, 1'b1, 1'b1, 5'h02, 1'b1, 1'b1, 1'b0);
    chk_status("simul", 4'd1, 1'b0, 1'b0, 1'b0);
    rsp(5'h02, 1'b1);

    // Underflow and clear.
    rsp(5'h02, 1'b1);
    chk_status("underflow", 4'd0, 1'b1, 1'b0, 1'b1);
    quiet(1'b1);
    chk("underflow_clear", underflow_err, 1'b0);

    // Watchdog: fires 16 edges after the request handshake.
    req(5'h01, 1'b1);
    repeat (15) quiet(1'b0);
    chk("wd_before", timeout_err, 1'b0);
    quiet(1'b0);
    chk("wd_fire", timeout_err, 1'b1);
    rsp(5'h02, 1'b1);
    chk_status("wd_resp", 4'd0, 1'b1, 1'b1, 1'b0);
    quiet(1'b0);
    quiet(1'b1);
    chk("wd_clear", timeout_err, 1'b0);

    // Random traffic with one asynchronous reset mid-run.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        nreset = 1'b0;
        model_reset();
        #1;
        chk_status("midreset", 4'd0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        nreset = 1'b1;
      end
      cyc(1'($urandom_range(0, 1)), ops[$urandom_range(0, 7)], ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 2) == 0), ops[$urandom_range(0, 7)], ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 4) != 0), ($urandom_range(0, 39) == 0));
    end
    quiet(1'b0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
